// File: rtl/regfile_rename.sv
// Architectural register file with a register status table (busy bit + ROB tag per register).
// Decode renames destinations to ROB tags; ROB commit writes data and releases only a matching rename.
module regfile_rename #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5,
    parameter int TAG_W  = 4,
    parameter int NREAD  = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      renameE_in,
    input  logic [IDX_W-1:0]          renameIdx_in,
    input  logic [TAG_W-1:0]          renameTag_in,
    input  logic                      commitE_in,
    input  logic [IDX_W-1:0]          commitIdx_in,
    input  logic [DATA_W-1:0]         commitData_in,
    input  logic [TAG_W-1:0]          commitTag_in,
    input  logic [NREAD*IDX_W-1:0]    rdIdx_in,
    output logic [NREAD*DATA_W-1:0]   rdData_out,
    output logic [NREAD-1:0]          rdBusy_out,
    output logic [NREAD*TAG_W-1:0]    rdTag_out
);

    localparam int NREG = 2 ** IDX_W;

    logic [DATA_W-1:0] data_q [NREG];
    logic [TAG_W-1:0]  tag_q  [NREG];
    logic [NREG-1:0]   busy_q;

    logic commit_valid;
    logic commit_release;
    logic rename_valid;

    // Entry 0 is never written, so x0 collapses to constants after reset.
    assign commit_valid   = commitE_in && (commitIdx_in != '0);
    assign commit_release = commit_valid && busy_q[commitIdx_in]
                            && (tag_q[commitIdx_in] == commitTag_in);
    assign rename_valid   = renameE_in && (renameIdx_in != '0) && !flush_in;

    // Later assignments take precedence: rename overrides commit release and flush.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                busy_q <= '0;
            end
            if (commit_valid) begin
                data_q[commitIdx_in] <= commitData_in;
            end
            if (commit_release) begin
                busy_q[commitIdx_in] <= 1'b0;
            end
            if (rename_valid) begin
                busy_q[renameIdx_in] <= 1'b1;
                tag_q[renameIdx_in]  <= renameTag_in;
            end
        end
    end

    logic [IDX_W-1:0] rd_idx;

    // Reads see pre-update state except for a tag-matching commit, which is bypassed.
    always_comb begin
        rdData_out = '0;
        rdBusy_out = '0;
        rdTag_out  = '0;
        rd_idx     = '0;
        for (int p = 0; p < NREAD; p++) begin
            rd_idx = rdIdx_in[p*IDX_W +: IDX_W];
            if (!rst_in && (rd_idx != '0)) begin
                if (commit_release && (commitIdx_in == rd_idx)) begin
                    rdData_out[p*DATA_W +: DATA_W] = commitData_in;
                end else begin
                    rdData_out[p*DATA_W +: DATA_W] = data_q[rd_idx];
                    rdBusy_out[p]                  = busy_q[rd_idx];
                    if (busy_q[rd_idx]) begin
                        rdTag_out[p*TAG_W +: TAG_W] = tag_q[rd_idx];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_rename.sv
// Self-checking bench for regfile_rename: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural register-status model.
module tb_regfile_rename;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;
    localparam int TAG_W  = 4;
    localparam int NREAD  = 2;
    localparam int NREG   = 2 ** IDX_W;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic                    rdy_in;
    logic                    flush_in;
    logic                    renameE_in;
    logic [IDX_W-1:0]        renameIdx_in;
    logic [TAG_W-1:0]        renameTag_in;
    logic                    commitE_in;
    logic [IDX_W-1:0]        commitIdx_in;
    logic [DATA_W-1:0]       commitData_in;
    logic [TAG_W-1:0]        commitTag_in;
    logic [NREAD*IDX_W-1:0]  rdIdx_in;
    logic [NREAD*DATA_W-1:0] rdData_out;
    logic [NREAD-1:0]        rdBusy_out;
    logic [NREAD*TAG_W-1:0]  rdTag_out;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    logic [DATA_W-1:0] m_data [NREG];
    logic [TAG_W-1:0]  m_tag  [NREG];
    bit                m_busy [NREG];

    regfile_rename #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .NREAD(NREAD)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .renameE_in(renameE_in), .renameIdx_in(renameIdx_in), .renameTag_in(renameTag_in),
        .commitE_in(commitE_in), .commitIdx_in(commitIdx_in), .commitData_in(commitData_in),
        .commitTag_in(commitTag_in), .rdIdx_in(rdIdx_in), .rdData_out(rdData_out),
        .rdBusy_out(rdBusy_out), .rdTag_out(rdTag_out)
    );

    always #5 clk_in = ~clk_in;

    // What a read must return, derived directly from the register-status rules.
    function automatic void exp_read(input logic [IDX_W-1:0] idx, output logic [DATA_W-1:0] d,
                                     output logic b, output logic [TAG_W-1:0] t);
        d = '0; b = 1'b0; t = '0;
        if (rst_in || idx == 0) return;
        if (commitE_in && commitIdx_in == idx && m_busy[idx] && m_tag[idx] == commitTag_in) begin
            d = commitData_in;
            return;
        end
        d = m_data[idx];
        b = m_busy[idx];
        t = b ? m_tag[idx] : '0;
    endfunction

    task automatic check_val(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic [DATA_W-1:0] d;
        logic              b;
        logic [TAG_W-1:0]  t;
        for (int p = 0; p < NREAD; p++) begin
            exp_read(rdIdx_in[p*IDX_W +: IDX_W], d, b, t);
            check_val($sformatf("model data p%0d", p), rdData_out[p*DATA_W +: DATA_W], d);
            check_val($sformatf("model busy p%0d", p), DATA_W'(rdBusy_out[p]), DATA_W'(b));
            check_val($sformatf("model tag p%0d", p), DATA_W'(rdTag_out[p*TAG_W +: TAG_W]), DATA_W'(t));
        end
    endtask

    // Model update at each clock edge from the inputs applied during that cycle.
    always @(posedge clk_in) begin
        bit release_hit;
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                m_data[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
            check_en = 1'b1;
        end else if (rdy_in) begin
            release_hit = commitE_in && commitIdx_in != 0 && m_busy[commitIdx_in]
                          && m_tag[commitIdx_in] == commitTag_in;
            if (commitE_in && commitIdx_in != 0) m_data[commitIdx_in] = commitData_in;
            if (release_hit) m_busy[commitIdx_in] = 1'b0;
            if (flush_in) for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            if (renameE_in && renameIdx_in != 0 && !flush_in) begin
                m_busy[renameIdx_in] = 1'b1;
                m_tag[renameIdx_in]  = renameTag_in;
            end
        end
    end

    always @(negedge clk_in) begin
        if (check_en) checkOutput();
    end

    task automatic applyStimulus(input bit rst, input bit rdy, input bit flush,
                                 input bit ren, input int ridx, input int rtag,
                                 input bit com, input int cidx, input logic [DATA_W-1:0] cdata,
                                 input int ctag, input int rd0, input int rd1);
        rst_in        = rst;
        rdy_in        = rdy;
        flush_in      = flush;
        renameE_in    = ren;
        renameIdx_in  = IDX_W'(ridx);
        renameTag_in  = TAG_W'(rtag);
        commitE_in    = com;
        commitIdx_in  = IDX_W'(cidx);
        commitData_in = cdata;
        commitTag_in  = TAG_W'(ctag);
        rdIdx_in      = {IDX_W'(rd1), IDX_W'(rd0)};
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk_in);
        #1;
    endtask

    task automatic check_port(input int p, input string name, input logic [DATA_W-1:0] d,
                              input bit b, input int t);
        check_val({name, " data"}, rdData_out[p*DATA_W +: DATA_W], d);
        check_val({name, " busy"}, DATA_W'(rdBusy_out[p]), DATA_W'(b));
        check_val({name, " tag"}, DATA_W'(rdTag_out[p*TAG_W +: TAG_W]), DATA_W'(t));
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_data[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, '0, 0, 5, 7);
        step();
        step();
        at_sample();
        check_port(0, "reset x5", '0, 0, 0);
        check_port(1, "reset x7", '0, 0, 0);

        applyStimulus(0, 1, 0, 0, 0, 0, 1, 5, 32'h0000_00AA, 0, 0, 0);
        step();
        applyStimulus(0, 1, 0, 1, 0, 3, 0, 0, '0, 0, 5, 0);
        at_sample();
        check_port(0, "commit x5", 32'hAA, 0, 0);
        step();
        applyStimulus(0, 1, 0, 1, 7, 4, 0, 0, '0, 0, 0, 0);
        at_sample();
        check_port(0, "rename x0", '0, 0, 0);

        step();
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 7, 32'h1234, 4, 7, 7);
        at_sample();
        check_port(0, "bypass x7", 32'h1234, 0, 0);
        step();
        applyStimulus(0, 1, 0, 1, 7, 2, 0, 0, '0, 0, 7, 0);
        at_sample();
        check_port(0, "post-commit x7", 32'h1234, 0, 0);
        step();
        applyStimulus(0, 1, 0, 1, 7, 6, 0, 0, '0, 0, 7, 0);
        at_sample();
        check_port(0, "renamed x7 t2", 32'h1234, 1, 2);
        step();
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 7, 32'h55, 2, 7, 0);
        at_sample();
        check_port(0, "stale commit read", 32'h1234, 1, 6);
        step();
        applyStimulus(0, 1, 0, 1, 3, 1, 0, 0, '0, 0, 7, 0);
        at_sample();
        check_port(0, "stale commit state", 32'h55, 1, 6);

        step();
        applyStimulus(0, 1, 0, 1, 9, 2, 0, 0, '0, 0, 0, 0);
        step();
        applyStimulus(0, 1, 0, 1, 12, 3, 0, 0, '0, 0, 3, 9);
        step();
        applyStimulus(0, 1, 1, 1, 4, 5, 0, 0, '0, 0, 3, 12);
        at_sample();
        check_port(0, "pre-flush x3", '0, 1, 1);
        check_port(1, "pre-flush x12", '0, 1, 3);
        step();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, '0, 0, 3, 4);
        at_sample();
        check_port(0, "flushed x3", '0, 0, 0);
        check_port(1, "flushed x4", '0, 0, 0);
        rdIdx_in = {IDX_W'(7), IDX_W'(12)};
        at_sample();
        check_port(0, "flushed x12", '0, 0, 0);
        check_port(1, "flushed x7", 32'h55, 0, 0);

        applyStimulus(0, 0, 0, 1, 9, 1, 1, 8, 32'hFF, 0, 8, 9);
        step();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, '0, 0, 8, 9);
        at_sample();
        check_port(0, "frozen x8", '0, 0, 0);
        check_port(1, "frozen x9", '0, 0, 0);

        step();
        applyStimulus(0, 1, 0, 1, 10, 7, 0, 0, '0, 0, 10, 7);
        step();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, '0, 0, 10, 7);
        at_sample();
        check_port(0, "reset pending x10", '0, 0, 0);
        step();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, '0, 0, 10, 7);
        at_sample();
        check_port(0, "after reset x10", '0, 0, 0);
        check_port(1, "after reset x7", '0, 0, 0);

        // Random traffic; small index range half the time to force collisions.
        for (int n = 0; n < 3000; n++) begin
            int  hi;
            int  cidx;
            bit  narrow;
            step();
            narrow = $urandom_range(0, 1) == 1;
            hi     = narrow ? 7 : NREG - 1;
            cidx   = $urandom_range(0, hi);
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                          $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, hi), $urandom_range(0, 15),
                          $urandom_range(0, 1) == 1, cidx, $urandom(),
                          $urandom_range(0, 15),
                          $urandom_range(0, 1) == 1 ? cidx : $urandom_range(0, hi),
                          $urandom_range(0, hi));
        end
        step();
        at_sample();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
